// File: rtl/fu_br_q_pkg.sv
// Shared decode constants and result-queue entry layout for the branch resolution unit.
package fu_br_q_pkg;

    localparam logic [5:0] BR_INST  = 6'h30;
    localparam logic [5:0] BSR_INST = 6'h34;
    localparam logic [2:0] JMP_GRP  = 3'b011;   // opcodes 6'h18..6'h1f
    localparam logic [1:0] CBR_GRP  = 2'b11;    // opcodes 6'h30..6'h3f

    localparam int unsigned ZERO_REG = 31;

    // Entry field widths; the top's width parameters must not exceed these.
    localparam int unsigned Q_XLEN   = 64;
    localparam int unsigned Q_PRF_W  = 6;
    localparam int unsigned Q_ROB_W  = 6;
    localparam int unsigned Q_MASK_W = 4;

    typedef struct packed {
        logic                valid;
        logic [Q_PRF_W-1:0]  dest_tag;
        logic [Q_XLEN-1:0]   value;
        logic [Q_ROB_W-1:0]  rob_idx;
        logic [Q_MASK_W-1:0] br_mask;
    } br_q_entry_t;

endpackage

// File: rtl/fu_br_q_br_eval.sv
// Combinational branch evaluation: direction, target, link need and mispredict check.
module fu_br_q_br_eval
    import fu_br_q_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] i_npc,
    input  logic [XLEN-1:0] i_opa,
    input  logic [XLEN-1:0] i_opb,
    input  logic [31:0]     i_inst,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    output logic            o_taken_c,
    output logic            o_link_c,
    output logic            o_mispredict_c,
    output logic [XLEN-1:0] o_recovery_target_c
);

    logic [5:0]      w_op;
    logic [2:0]      w_func;
    logic            w_is_jump;
    logic            w_is_uncond;
    logic            w_is_cond;
    logic            w_cond;
    logic            w_opa_zero;
    logic [XLEN-1:0] w_disp;
    logic [XLEN-1:0] w_target;
    logic            w_unused_fields;

    assign w_op        = i_inst[31:26];
    assign w_func      = i_inst[28:26];
    assign w_is_jump   = (i_inst[31:29] == JMP_GRP);
    assign w_is_uncond = (w_op == BR_INST) || (w_op == BSR_INST);
    assign w_is_cond   = (i_inst[31:30] == CBR_GRP) && !w_is_uncond;
    assign w_opa_zero  = (i_opa == '0);

    // Register A field and the low target bits of regB play no part in resolution.
    assign w_unused_fields = ^{i_inst[25:21], i_opb[1:0]};

    assign w_disp = {{(XLEN-23){i_inst[20]}}, i_inst[20:0], 2'b00};

    always_comb begin
        w_cond = 1'b0;
        case (w_func[1:0])
            2'b00:   w_cond = !i_opa[0];
            2'b01:   w_cond = w_opa_zero;
            2'b10:   w_cond = i_opa[XLEN-1];
            default: w_cond = i_opa[XLEN-1] || w_opa_zero;
        endcase
        w_cond = w_cond ^ w_func[2];
    end

    assign w_target  = w_is_jump ? {i_opb[XLEN-1:2], 2'b00} : (i_npc + w_disp);
    assign o_taken_c = w_is_jump || w_is_uncond || (w_is_cond && w_cond);
    assign o_link_c  = w_is_jump || w_is_uncond;

    assign o_mispredict_c      = (o_taken_c != i_pred_taken) ||
                                 (o_taken_c && (w_target != i_pred_target));
    assign o_recovery_target_c = o_taken_c ? w_target : i_npc;

endmodule

// File: rtl/fu_br_q.sv
// Branch resolution unit with a DEPTH-entry link-writeback queue that tracks branch masks
// for squash and clear.
module fu_br_q
    import fu_br_q_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned PRF_IDX_W = 6,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned BR_MASK_W = 4,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 ready_o,
    input  logic [XLEN-1:0]      npc_i,
    input  logic [XLEN-1:0]      opa_i,
    input  logic [XLEN-1:0]      opb_i,
    input  logic [31:0]          inst_i,
    input  logic [PRF_IDX_W-1:0] dest_tag_i,
    input  logic [ROB_IDX_W:0]   rob_idx_i,
    input  logic [BR_MASK_W-1:0] br_mask_i,
    input  logic                 pred_taken_i,
    input  logic [XLEN-1:0]      pred_target_i,
    input  logic                 rob_br_recovery_i,
    input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
    input  logic                 br_clear_i,
    input  logic [BR_MASK_W-1:0] br_clear_tag_i,
    output logic                 resolve_valid_o,
    output logic [ROB_IDX_W:0]   resolve_rob_idx_o,
    output logic                 resolve_taken_o,
    output logic                 mispredict_o,
    output logic [XLEN-1:0]      recovery_target_o,
    output logic                 wb_valid_o,
    input  logic                 wb_ack_i,
    output logic [PRF_IDX_W-1:0] wb_dest_tag_o,
    output logic [XLEN-1:0]      wb_value_o,
    output logic [ROB_IDX_W:0]   wb_rob_idx_o,
    output logic [BR_MASK_W-1:0] wb_br_mask_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    br_q_entry_t          r_q [DEPTH];
    br_q_entry_t          w_q_next [DEPTH];
    br_q_entry_t          w_new_entry;
    br_q_entry_t          w_head;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic                 r_resolve_valid;
    logic [ROB_IDX_W:0]   r_resolve_rob_idx;
    logic                 r_resolve_taken;
    logic                 r_mispredict;
    logic [XLEN-1:0]      r_recovery_target;

    logic                 w_taken;
    logic                 w_link;
    logic                 w_mispredict;
    logic [XLEN-1:0]      w_recovery_target;
    logic                 w_ready;
    logic                 w_nonempty;
    logic                 w_fire;
    logic                 w_drop;
    logic                 w_accept;
    logic                 w_enq;
    logic                 w_pop;
    logic [BR_MASK_W-1:0] w_clear_mask;

    fu_br_q_br_eval #(
        .XLEN (XLEN)
    ) u_br_eval (
        .i_npc               (npc_i),
        .i_opa               (opa_i),
        .i_opb               (opb_i),
        .i_inst              (inst_i),
        .i_pred_taken        (pred_taken_i),
        .i_pred_target       (pred_target_i),
        .o_taken_c           (w_taken),
        .o_link_c            (w_link),
        .o_mispredict_c      (w_mispredict),
        .o_recovery_target_c (w_recovery_target)
    );

    assign w_ready      = (r_count < CNT_W'(DEPTH));
    assign w_nonempty   = (r_count != '0);
    assign w_head       = r_q[r_head];
    assign w_fire       = start_i && w_ready;
    // An issue whose own mask is being squashed this cycle leaves no trace at all.
    assign w_drop       = rob_br_recovery_i && ((br_mask_i & rob_br_tag_fix_i) != '0);
    assign w_accept     = w_fire && !w_drop;
    assign w_enq        = w_accept && w_link && (dest_tag_i != PRF_IDX_W'(ZERO_REG));
    assign w_clear_mask = br_clear_i ? br_clear_tag_i : '0;
    // Squashed holes at the head retire on their own without a CDB handshake.
    assign w_pop        = w_nonempty && (!w_head.valid || wb_ack_i);

    always_comb begin
        w_new_entry          = '0;
        w_new_entry.valid    = 1'b1;
        w_new_entry.dest_tag = Q_PRF_W'(dest_tag_i);
        w_new_entry.value    = Q_XLEN'(npc_i);
        w_new_entry.rob_idx  = Q_ROB_W'(rob_idx_i);
        w_new_entry.br_mask  = Q_MASK_W'(br_mask_i & ~w_clear_mask);
    end

    // Squash tests the mask before this cycle's clear is applied.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_q_next[PTR_W'(i)] = r_q[PTR_W'(i)];
            if (rob_br_recovery_i &&
                ((BR_MASK_W'(r_q[PTR_W'(i)].br_mask) & rob_br_tag_fix_i) != '0)) begin
                w_q_next[PTR_W'(i)].valid = 1'b0;
            end
            w_q_next[PTR_W'(i)].br_mask = r_q[PTR_W'(i)].br_mask & ~Q_MASK_W'(w_clear_mask);
        end
        if (w_enq) begin
            w_q_next[r_tail] = w_new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= '{default: '0};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_q    <= w_q_next;
            r_head <= r_head + PTR_W'(w_pop);
            r_tail <= r_tail + PTR_W'(w_enq);
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resolve_valid   <= 1'b0;
            r_resolve_rob_idx <= '0;
            r_resolve_taken   <= 1'b0;
            r_mispredict      <= 1'b0;
            r_recovery_target <= '0;
        end else begin
            r_resolve_valid <= w_accept;
            r_resolve_taken <= w_accept && w_taken;
            r_mispredict    <= w_accept && w_mispredict;
            if (w_accept) begin
                r_resolve_rob_idx <= rob_idx_i;
                r_recovery_target <= w_recovery_target;
            end
        end
    end

    assign ready_o           = w_ready;
    assign resolve_valid_o   = r_resolve_valid;
    assign resolve_rob_idx_o = r_resolve_rob_idx;
    assign resolve_taken_o   = r_resolve_taken;
    assign mispredict_o      = r_mispredict;
    assign recovery_target_o = r_recovery_target;

    assign wb_valid_o    = w_nonempty && w_head.valid;
    assign wb_dest_tag_o = PRF_IDX_W'(w_head.dest_tag);
    assign wb_value_o    = XLEN'(w_head.value);
    assign wb_rob_idx_o  = (ROB_IDX_W + 1)'(w_head.rob_idx);
    assign wb_br_mask_o  = BR_MASK_W'(w_head.br_mask);

endmodule

// File: tb/tb_fu_br_q.sv
// Randomized bench for fu_br_q against a queue-based behavioural model, plus directed scenarios.
module tb_fu_br_q;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        ready_o;
    logic [63:0] npc_i = '0;
    logic [63:0] opa_i = '0;
    logic [63:0] opb_i = '0;
    logic [31:0] inst_i = '0;
    logic [5:0]  dest_tag_i = '0;
    logic [5:0]  rob_idx_i = '0;
    logic [3:0]  br_mask_i = '0;
    logic        pred_taken_i = 1'b0;
    logic [63:0] pred_target_i = '0;
    logic        rob_br_recovery_i = 1'b0;
    logic [3:0]  rob_br_tag_fix_i = '0;
    logic        br_clear_i = 1'b0;
    logic [3:0]  br_clear_tag_i = '0;
    logic        resolve_valid_o;
    logic [5:0]  resolve_rob_idx_o;
    logic        resolve_taken_o;
    logic        mispredict_o;
    logic [63:0] recovery_target_o;
    logic        wb_valid_o;
    logic        wb_ack_i = 1'b0;
    logic [5:0]  wb_dest_tag_o;
    logic [63:0] wb_value_o;
    logic [5:0]  wb_rob_idx_o;
    logic [3:0]  wb_br_mask_o;

    fu_br_q #(
        .XLEN(64), .PRF_IDX_W(6), .ROB_IDX_W(5), .BR_MASK_W(4), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .ready_o(ready_o),
        .npc_i(npc_i), .opa_i(opa_i), .opb_i(opb_i), .inst_i(inst_i),
        .dest_tag_i(dest_tag_i), .rob_idx_i(rob_idx_i), .br_mask_i(br_mask_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .rob_br_recovery_i(rob_br_recovery_i), .rob_br_tag_fix_i(rob_br_tag_fix_i),
        .br_clear_i(br_clear_i), .br_clear_tag_i(br_clear_tag_i),
        .resolve_valid_o(resolve_valid_o), .resolve_rob_idx_o(resolve_rob_idx_o),
        .resolve_taken_o(resolve_taken_o), .mispredict_o(mispredict_o),
        .recovery_target_o(recovery_target_o), .wb_valid_o(wb_valid_o),
        .wb_ack_i(wb_ack_i), .wb_dest_tag_o(wb_dest_tag_o), .wb_value_o(wb_value_o),
        .wb_rob_idx_o(wb_rob_idx_o), .wb_br_mask_o(wb_br_mask_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [5:0]  tag;
        logic [63:0] val;
        logic [5:0]  rob;
        logic [3:0]  mask;
    } ent_t;

    ent_t        mq[$];
    bit          e_rv, e_mis, e_taken;
    logic [5:0]  e_ridx;
    logic [63:0] e_rtgt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Branch semantics written directly from the ISA rules with plain arithmetic.
    function automatic void ref_eval(input logic [31:0] inst, input logic [63:0] npc,
                                     input logic [63:0] opa, input logic [63:0] opb,
                                     output bit taken, output logic [63:0] tgt,
                                     output bit link);
        logic [5:0]    op = inst[31:26];
        logic [2:0]    fn = inst[28:26];
        longint signed a = opa;
        longint signed disp = $signed(inst[20:0]);
        bit            c = 1'b0;
        taken = 1'b0;
        link  = 1'b0;
        tgt   = npc + 64'(disp * 4);
        if (op >= 6'h18 && op <= 6'h1F) begin
            taken = 1'b1;
            link  = 1'b1;
            tgt   = opb - (opb % 64'd4);
        end else if (op == 6'h30 || op == 6'h34) begin
            taken = 1'b1;
            link  = 1'b1;
        end else if (op >= 6'h30) begin
            case (fn[1:0])
                2'd0:    c = ((opa & 64'd1) == 64'd0);
                2'd1:    c = (a == 0);
                2'd2:    c = (a < 0);
                default: c = (a <= 0);
            endcase
            taken = c ^ fn[2];
        end
    endfunction

    task automatic model_step();
        bit          fire, drop, taken, link, pop;
        logic [63:0] tgt;
        ent_t        e;
        fire = start_i && (mq.size() < DEPTH);
        drop = rob_br_recovery_i && ((br_mask_i & rob_br_tag_fix_i) != 4'd0);
        ref_eval(inst_i, npc_i, opa_i, opb_i, taken, tgt, link);
        e_rv    = fire && !drop;
        e_taken = e_rv && taken;
        e_mis   = e_rv && ((taken != pred_taken_i) || (taken && tgt != pred_target_i));
        if (e_rv) begin
            e_ridx = rob_idx_i;
            e_rtgt = taken ? tgt : npc_i;
        end
        pop = (mq.size() != 0) && (!mq[0].v || wb_ack_i);
        foreach (mq[i]) begin
            if (rob_br_recovery_i && ((mq[i].mask & rob_br_tag_fix_i) != 4'd0)) mq[i].v = 1'b0;
            if (br_clear_i) mq[i].mask = mq[i].mask & ~br_clear_tag_i;
        end
        if (pop) void'(mq.pop_front());
        if (e_rv && link && dest_tag_i != 6'd31) begin
            e.v    = 1'b1;
            e.tag  = dest_tag_i;
            e.val  = npc_i;
            e.rob  = rob_idx_i;
            e.mask = br_mask_i & ~(br_clear_i ? br_clear_tag_i : 4'd0);
            mq.push_back(e);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_rv = 1'b0; e_mis = 1'b0; e_taken = 1'b0; e_ridx = '0; e_rtgt = '0;
    endtask

    task automatic check_outputs();
        bit exp_wb = 1'b0;
        if (mq.size() != 0) exp_wb = mq[0].v;
        check("ready", ready_o, 64'(mq.size() < DEPTH));
        check("resolve_valid", resolve_valid_o, 64'(e_rv));
        check("mispredict", mispredict_o, 64'(e_mis));
        check("resolve_taken", resolve_taken_o, 64'(e_taken));
        if (e_rv) begin
            check("resolve_rob_idx", resolve_rob_idx_o, 64'(e_ridx));
            check("recovery_target", recovery_target_o, e_rtgt);
        end
        check("wb_valid", wb_valid_o, 64'(exp_wb));
        if (exp_wb) begin
            check("wb_dest_tag", wb_dest_tag_o, 64'(mq[0].tag));
            check("wb_value", wb_value_o, mq[0].val);
            check("wb_rob_idx", wb_rob_idx_o, 64'(mq[0].rob));
            check("wb_br_mask", wb_br_mask_o, 64'(mq[0].mask));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        start_i = 1'b0; rob_br_recovery_i = 1'b0; rob_br_tag_fix_i = '0;
        br_clear_i = 1'b0; br_clear_tag_i = '0;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [63:0] npc, input logic [63:0] opa,
                         input logic [63:0] opb, input logic [5:0] dest, input logic [5:0] rob,
                         input logic [3:0] mask, input bit pt, input logic [63:0] ptgt);
        start_i = 1'b1; inst_i = inst; npc_i = npc; opa_i = opa; opb_i = opb;
        dest_tag_i = dest; rob_idx_i = rob; br_mask_i = mask;
        pred_taken_i = pt; pred_target_i = ptgt;
    endtask

    task automatic rand_inputs();
        logic [5:0]  op;
        bit          taken, link;
        logic [63:0] tgt;
        case ($urandom_range(0, 3))
            0:       op = 6'h18;
            1:       op = ($urandom_range(0, 1) != 0) ? 6'h30 : 6'h34;
            default: op = 6'h30 + 6'($urandom_range(0, 15));
        endcase
        inst_i = {op, 5'($urandom), 21'($urandom)};
        case ($urandom_range(0, 5))
            0:       opa_i = 64'd0;
            1:       opa_i = 64'd1;
            2:       opa_i = 64'hFFFF_FFFF_FFFF_FFFF;
            3:       opa_i = 64'h8000_0000_0000_0000;
            4:       opa_i = 64'd2;
            default: opa_i = {$urandom, $urandom};
        endcase
        opb_i = {$urandom, $urandom};
        npc_i = {$urandom, $urandom} & ~64'd3;
        ref_eval(inst_i, npc_i, opa_i, opb_i, taken, tgt, link);
        pred_taken_i  = ($urandom_range(0, 3) != 0) ? taken : !taken;
        pred_target_i = ($urandom_range(0, 3) != 0) ? tgt : (tgt ^ 64'h10);
        start_i    = ($urandom_range(0, 9) < 6);
        dest_tag_i = ($urandom_range(0, 3) == 0) ? 6'd31 : 6'($urandom_range(0, 63));
        rob_idx_i  = 6'($urandom);
        br_mask_i  = 4'($urandom);
        rob_br_recovery_i = ($urandom_range(0, 9) == 0);
        rob_br_tag_fix_i  = 4'd1 << $urandom_range(0, 3);
        br_clear_i        = ($urandom_range(0, 6) == 0);
        br_clear_tag_i    = 4'd1 << $urandom_range(0, 3);
        wb_ack_i          = ($urandom_range(0, 1) != 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clk);
        check_outputs();
        check("rst_ready", ready_o, 64'd1);
        check("rst_rob_idx", resolve_rob_idx_o, 64'd0);
        check("rst_target", recovery_target_o, 64'd0);
        rst = 1'b0;

        // BEQ taken on opa==0 while predicted not-taken.
        issue({6'h39, 5'd1, 21'd16}, 64'h100, 64'd0, 64'd0, 6'd3, 6'd9, 4'd0, 1'b0, 64'd0);
        cycle();
        check("beq_mispredict", mispredict_o, 64'd1);
        check("beq_target", recovery_target_o, 64'h140);
        check("beq_taken", resolve_taken_o, 64'd1);
        check("beq_no_enqueue", wb_valid_o, 64'd0);

        // BNE with a backward displacement, predicted correctly.
        issue({6'h3D, 5'd1, 21'h1FFFFC}, 64'h200, 64'd5, 64'd0, 6'd3, 6'd10, 4'd0, 1'b1, 64'h1F0);
        cycle();
        check("bne_resolve", resolve_valid_o, 64'd1);
        check("bne_mispredict", mispredict_o, 64'd0);

        // Jump with link to tag 5; held until acked.
        wb_ack_i = 1'b0;
        issue({6'h18, 5'd0, 21'd0}, 64'h400, 64'd0, 64'h1003, 6'd5, 6'd11, 4'd0, 1'b1, 64'h1000);
        cycle();
        check("jsr_target", recovery_target_o, 64'h1000);
        check("jsr_wb_value", wb_value_o, 64'h400);
        check("jsr_wb_tag", wb_dest_tag_o, 64'd5);
        idle();
        cycle();
        cycle();
        check("jsr_held", wb_valid_o, 64'd1);
        wb_ack_i = 1'b1;
        cycle();
        check("jsr_popped", wb_valid_o, 64'd0);

        // Fill the queue with BSRs, try one more, then free a slot.
        wb_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue({6'h34, 5'd0, 21'd1}, 64'h800 + 64'(i * 16), 64'd0, 64'd0, 6'(i + 1),
                  6'(i + 20), 4'd0, 1'b1, 64'h804 + 64'(i * 16));
            cycle();
            if (i == 3) check("full_ready", ready_o, 64'd0);
        end
        check("full_no_accept", resolve_valid_o, 64'd0);
        idle();
        wb_ack_i = 1'b1;
        cycle();
        check("ack_ready", ready_o, 64'd1);
        for (int i = 0; i < 4; i++) cycle();

        // Squash by mask leaves holes; only the middle entry is written back.
        wb_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue({6'h34, 5'd0, 21'd2}, 64'hA00 + 64'(i * 16), 64'd0, 64'd0, 6'(i + 1),
                  6'(i + 1), (i == 1) ? 4'b0010 : 4'b0001, 1'b1, 64'hA08 + 64'(i * 16));
            cycle();
        end
        idle();
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0001;
        cycle();
        check("squash_head_hole", wb_valid_o, 64'd0);
        idle();
        cycle();
        check("squash_survivor", wb_valid_o, 64'd1);
        check("squash_survivor_tag", wb_dest_tag_o, 64'd2);
        wb_ack_i = 1'b1;
        cycle();
        check("squash_tail_hole", wb_valid_o, 64'd0);
        cycle();

        // Clear on the enqueue cycle strips the bit from the new entry.
        wb_ack_i = 1'b0;
        issue({6'h34, 5'd0, 21'd3}, 64'hC00, 64'd0, 64'd0, 6'd7, 6'd7, 4'b0011, 1'b1, 64'hC0C);
        br_clear_i     = 1'b1;
        br_clear_tag_i = 4'b0010;
        cycle();
        check("clear_enq_mask", wb_br_mask_o, 64'b0001);
        idle();
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0010;
        cycle();
        check("clear_survives", wb_valid_o, 64'd1);
        idle();
        wb_ack_i = 1'b1;
        cycle();

        // Randomized traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle();
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs();
                check("midrst_count", ready_o, 64'd1);
                @(negedge clk);
                rst = 1'b0;
            end
            rand_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
